// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single register-file write port.
// Two producers (A = ALU path, B = load/store path) each park one write in a
// private holding buffer. The buffered writes are granted to the port one per
// cycle, oldest first. Ties in age are broken by a round-robin pointer. The
// port signals come from a register stage. pending_mask tells hazard logic
// which registers still have a write in flight.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                      CLK,
    input  logic                      RESET,

    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [ADDR_W-1:0]         a_rd,
    input  logic [DATA_W-1:0]         a_data,

    input  logic                      b_valid,
    output logic                      b_ready,
    input  logic [ADDR_W-1:0]         b_rd,
    input  logic [DATA_W-1:0]         b_data,

    output logic                      WriteEnable,
    output logic [ADDR_W-1:0]         WriteRegister,
    output logic [DATA_W-1:0]         WriteData,

    output logic [(1<<ADDR_W)-1:0]    pending_mask
);

    localparam int NREG = 1 << ADDR_W;

    // Holding buffers
    logic              fullA;
    logic              fullB;
    logic [ADDR_W-1:0] rdA;
    logic [ADDR_W-1:0] rdB;
    logic [DATA_W-1:0] dataA;
    logic [DATA_W-1:0] dataB;

    // Age bookkeeping: aOlder is meaningful only while tieAge is clear.
    // tieAge marks that both buffers were loaded on the same edge.
    logic              aOlder;
    logic              tieAge;
    logic              rr;

    logic              grantA;
    logic              grantB;
    logic              tieGrant;
    logic              acceptA;
    logic              acceptB;
    logic              keepB;
    logic              keepA;

    logic [NREG-1:0]   pendingNext;

    // Grant selection: a lone full buffer always wins; when both are full the
    // older wins, and a same-cycle tie is resolved by rr.
    always_comb begin
        grantA   = 1'b0;
        grantB   = 1'b0;
        tieGrant = 1'b0;
        if (fullA && fullB) begin
            if (tieAge) begin
                tieGrant = 1'b1;
                if (rr) begin
                    grantB = 1'b1;
                end else begin
                    grantA = 1'b1;
                end
            end else if (aOlder) begin
                grantA = 1'b1;
            end else begin
                grantB = 1'b1;
            end
        end else if (fullA) begin
            grantA = 1'b1;
        end else if (fullB) begin
            grantB = 1'b1;
        end
    end

    // A buffer being drained this cycle can take a new write at the same edge,
    // which is what lets a lone producer stream at one write per cycle.
    assign a_ready = !RESET && (!fullA || grantA);
    assign b_ready = !RESET && (!fullB || grantB);
    assign acceptA = a_valid && a_ready;
    assign acceptB = b_valid && b_ready;

    // A buffer that is full and not granted keeps its entry across the edge.
    assign keepA = fullA && !grantA;
    assign keepB = fullB && !grantB;

    // Buffer A: load on accept, release on grant.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fullA <= 1'b0;
            rdA   <= '0;
            dataA <= '0;
        end else if (acceptA) begin
            fullA <= 1'b1;
            rdA   <= a_rd;
            dataA <= a_data;
        end else if (grantA) begin
            fullA <= 1'b0;
        end
    end

    // Buffer B: load on accept, release on grant.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fullB <= 1'b0;
            rdB   <= '0;
            dataB <= '0;
        end else if (acceptB) begin
            fullB <= 1'b1;
            rdB   <= b_rd;
            dataB <= b_data;
        end else if (grantB) begin
            fullB <= 1'b0;
        end
    end

    // Age tracking and round-robin pointer. A newly accepted entry is younger
    // than any entry that survives the edge in the other buffer; rr only
    // advances when it actually decided a tie.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            aOlder <= 1'b0;
            tieAge <= 1'b0;
            rr     <= 1'b0;
        end else begin
            if (tieGrant) begin
                rr <= !rr;
            end
            if (acceptA && acceptB) begin
                tieAge <= 1'b1;
            end else if (acceptA) begin
                tieAge <= 1'b0;
                aOlder <= !keepB;
            end else if (acceptB) begin
                tieAge <= 1'b0;
                aOlder <= keepA;
            end
        end
    end

    // Output stage: load the granted write; x0 takes a slot but never enables.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            WriteEnable   <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else if (grantA) begin
            WriteEnable   <= (rdA != '0);
            WriteRegister <= rdA;
            WriteData     <= dataA;
        end else if (grantB) begin
            WriteEnable   <= (rdB != '0);
            WriteRegister <= rdB;
            WriteData     <= dataB;
        end else begin
            WriteEnable   <= 1'b0;
        end
    end

    // Pending mask from buffered and staged writes; x0 is never pending.
    always_comb begin
        pendingNext = '0;
        if (fullA) begin
            pendingNext[rdA] = 1'b1;
        end
        if (fullB) begin
            pendingNext[rdB] = 1'b1;
        end
        if (WriteEnable) begin
            pendingNext[WriteRegister] = 1'b1;
        end
        pendingNext[0] = 1'b0;
    end

    assign pending_mask = pendingNext;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and sequencer for the single write port of the 32 x 32-bit register file. It accepts write-back requests from two producers, the ALU path (A) and the load/store path (B). Each request is parked in a one-entry holding buffer, and the buffered writes are granted to the port one per cycle, oldest first. The port-side signals are driven from a register stage. A pending-register mask is exported for hazard/stall logic in the single-cycle core.

## Interface
Parameters:
- DATA_W, 32, width of write data
- ADDR_W, 5, register index width (2^ADDR_W registers)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- a_valid  in  1  requester A write-back request
- a_ready  out  1  A buffer can accept this cycle
- a_rd  in  ADDR_W  A destination register
- a_data  in  DATA_W  A write value
- b_valid  in  1  requester B write-back request
- b_ready  out  1  B buffer can accept this cycle
- b_rd  in  ADDR_W  B destination register
- b_data  in  DATA_W  B write value
- WriteEnable  out  1  to register file write enable (registered)
- WriteRegister  out  ADDR_W  to register file write index (registered)
- WriteData  out  DATA_W  to register file write data (registered)
- pending_mask  out  2^ADDR_W  bit r set if a write to r is buffered or in the output stage

## Operation
- State:
  - per-requester buffer: full flag, rd, data;
  - age flag a_older;
  - round-robin pointer rr: 0 means A is preferred, 1 means B;
  - output registers.
- Accept: a transfer on A occurs when a_valid && a_ready. It loads buf_a with rd/data and sets full_a. B behaves identically.
- Ready rule: a_ready = !RESET && (!full_a || grant_a). A buffer freed by a grant this cycle may reload in the same cycle. B is identical.
- Grant (combinational, one per cycle):
  - only A full: grant A.
  - only B full: grant B.
  - both full, different ages: grant the older.
  - both full, accepted in the same cycle: grant per rr, then toggle rr.
  - rr toggles only on these simultaneous-age ties.
- Age tracking: a_older is set when A is accepted while B is empty or being drained. It is cleared symmetrically for B. On simultaneous acceptance into two empty (or both-draining) buffers, a tie flag is set instead.
- Output stage: on a grant, WriteRegister/WriteData load from the granted buffer and WriteEnable = (rd != 0). With no grant, WriteEnable = 0 and WriteRegister/WriteData hold their previous values.
- x0 writes are accepted and consumed through a normal grant slot, but never assert WriteEnable.
- Same-rd requests in both buffers: the older is written first, so the final register value is the younger's data.
- pending_mask: bit set for rd of each full buffer, plus WriteRegister when WriteEnable = 1. Bit 0 is always 0. Combinational from state.

## Timing
- Reset values: WriteEnable 0, WriteRegister 0, WriteData 0, buffers empty, rr 0, a_older 0, pending_mask 0, a_ready/b_ready 0 while RESET is high.
- RESET mid-operation discards buffered and staged writes immediately. No write reaches the register file after RESET asserts.
- Latency: accepted at edge N, granted at edge N+1 (when uncontested), WriteEnable high in cycle N+1..N+2, register file written at edge N+2.
- Contested: the loser is granted one edge later. Maximum wait for any accepted request is 1 extra cycle.
- Throughput:
  - one write per cycle total.
  - a single requester alone streams at 1 per cycle (ready stays high via the grant bypass).
  - both requesters streaming continuously each get 1 per 2 cycles.
- No combinational path from a_valid/b_valid to WriteEnable. The a_ready/b_ready paths are combinational from internal state only.

## Test plan
- Reset, then check outputs:
  - RESET pulse mid-stream: all outputs 0 and a_ready = b_ready = 0 during RESET.
  - first cycle after RESET releases: ready = 1, pending_mask = 0.
- Lone A stream: A writes rd 1..4 with data 0x11..0x44 back-to-back. Required response: WriteEnable high 4 consecutive cycles, starting 1 cycle after the first accept, with matching rd/data, and a_ready never low.
- Simultaneous accept: A writes (rd5, 0xA), B writes (rd6, 0xB) in the same cycle, rr = 0. Required response: rd5 written first, rd6 next cycle, rr = 1 afterwards, and the next tie goes to B first.
- Age order with same rd: A accepted (rd7, 0x1) a cycle before B (rd7, 0x2) while A is blocked. Required response: write order 0x1 then 0x2, final reg7 = 0x2.
- x0 write: B writes (rd0, 0xDEAD). Required response: b_ready handshake completes, WriteEnable stays 0, pending_mask bit 0 stays 0.
- Pending mask: A writes rd9. Required response: pending_mask = 1<<9 from the cycle after the accept through the cycle WriteEnable is high, then 0.
